seq_div_64: RTL and testbench

Sequential 64-bit integer divider, the inverse counterpart to the multiplier/adder datapath. Computes quotient and remainder of signed or unsigned operands with radix-2 non-restoring division, one quotient bit per cycle. Sits beside the Booth multiplier in the arithmetic unit. Valid/ready handshakes on both operand and result sides.

---
 rtl/arith_pkg.sv | 32 +++
 rtl/addsub_65.sv | 37 +++
 rtl/seq_div_64.sv | 188 ++++++++++++++++++
 tb/tb_seq_div_64.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: widths, divider FSM states, CLA slice helper.
package arith_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned CNT_W = 6;
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

    // 4-bit carry-lookahead add; returns {carry_out, sum}.
    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[4], p ^ c[3:0]};
    endfunction

endpackage

// File: rtl/addsub_65.sv
// Combinational 65-bit add/subtract: 4-bit CLA slices, carry-select between slices.
module addsub_65
    import arith_pkg::*;
(
    input  logic [64:0] a,
    input  logic [64:0] b,
    input  logic        sub,
    output logic [64:0] sum_c
);

    localparam int unsigned NSL = 17;
    localparam int unsigned WX  = NSL * 4;

    logic [WX-1:0] a_x;
    logic [WX-1:0] b_x;
    logic [WX-1:0] s_x;
    logic [NSL:0]  c;
    logic          unused_hi;

    // Subtraction as a + ~b + 1; operands padded to a whole number of slices.
    assign a_x  = {3'b000, a};
    assign b_x  = {3'b000, b ^ {65{sub}}};
    assign c[0] = sub;

    for (genvar gi = 0; gi < NSL; gi++) begin : g_slice
        logic [4:0] r0;
        logic [4:0] r1;
        assign r0 = cla4(a_x[4*gi +: 4], b_x[4*gi +: 4], 1'b0);
        assign r1 = cla4(a_x[4*gi +: 4], b_x[4*gi +: 4], 1'b1);
        assign c[gi+1]       = c[gi] ? r1[4]   : r0[4];
        assign s_x[4*gi +: 4] = c[gi] ? r1[3:0] : r0[3:0];
    end

    assign sum_c     = s_x[64:0];
    assign unused_hi = ^{s_x[WX-1:65], c[NSL]};

endmodule

// File: rtl/seq_div_64.sv
// Sequential radix-2 non-restoring divider, signed/unsigned, one quotient bit per cycle.
module seq_div_64 #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            div_by_zero
);
    import arith_pkg::*;

    localparam int unsigned PW = XLEN + 1;
    localparam logic [XLEN-1:0] MIN_V = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t        state;
    div_state_t        state_n;
    logic [XLEN-1:0]   q_reg;
    logic [XLEN-1:0]   d_reg;
    logic [PW-1:0]     p_reg;
    logic [CNT_W-1:0]  cnt;
    logic              sgn;
    logic              sign_q;
    logic              sign_r;

    logic [PW-1:0]     a0, b0, s0;
    logic [PW-1:0]     a1, b1, s1;
    logic [PW-1:0]     a2, b2, s2;
    logic              sub0, sub1, sub2;
    logic              unused_msb;

    logic              dz_c;
    logic              ovf_c;
    logic              dvd_neg_c;
    logic              dvs_neg_c;
    logic [PW-1:0]     p_sh_c;

    // In PREP q_reg/d_reg still hold the raw latched operands.
    assign dz_c       = (d_reg == '0);
    assign ovf_c      = sgn && (q_reg == MIN_V) && (d_reg == '1);
    assign dvd_neg_c  = sgn & q_reg[XLEN-1];
    assign dvs_neg_c  = sgn & d_reg[XLEN-1];
    assign p_sh_c     = {p_reg[XLEN-1:0], q_reg[XLEN-1]};
    assign unused_msb = s1[XLEN] ^ s2[XLEN];

    addsub_65 u_add0 (.a(a0), .b(b0), .sub(sub0), .sum_c(s0));
    addsub_65 u_add1 (.a(a1), .b(b1), .sub(sub1), .sum_c(s1));
    addsub_65 u_add2 (.a(a2), .b(b2), .sub(sub2), .sum_c(s2));

    // Adder 0: dividend negation, iteration step, final restore.
    always_comb begin
        a0   = '0;
        b0   = '0;
        sub0 = 1'b0;
        case (state)
            PREP: begin
                b0   = {1'b0, q_reg};
                sub0 = 1'b1;
            end
            ITER: begin
                a0   = p_sh_c;
                b0   = {1'b0, d_reg};
                sub0 = ~p_reg[XLEN];
            end
            FIX: begin
                a0 = p_reg;
                b0 = p_reg[XLEN] ? {1'b0, d_reg} : '0;
            end
            default: ;
        endcase
    end

    // Adder 1: divisor negation, then remainder sign fix on the restored value.
    always_comb begin
        a1   = '0;
        b1   = '0;
        sub1 = 1'b0;
        case (state)
            PREP: begin
                b1   = {1'b0, d_reg};
                sub1 = 1'b1;
            end
            FIX: begin
                b1   = s0;
                sub1 = 1'b1;
            end
            default: ;
        endcase
    end

    // Adder 2: quotient sign fix.
    always_comb begin
        a2   = '0;
        b2   = '0;
        sub2 = 1'b0;
        if (state == FIX) begin
            b2   = {1'b0, q_reg};
            sub2 = 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (in_valid && in_ready) state_n = PREP;
            PREP: state_n = (dz_c || ovf_c) ? DONE : ITER;
            ITER: if (cnt == '0) state_n = FIX;
            FIX:  state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg       <= '0;
            d_reg       <= '0;
            p_reg       <= '0;
            cnt         <= '0;
            sgn         <= 1'b0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            in_ready  <= (state_n == IDLE);
            out_valid <= (state_n == DONE);
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        q_reg <= dividend;
                        d_reg <= divisor;
                        sgn   <= is_signed;
                    end
                end
                PREP: begin
                    if (dz_c) begin
                        quotient    <= '1;
                        remainder   <= q_reg;
                        div_by_zero <= 1'b1;
                    end else if (ovf_c) begin
                        quotient    <= MIN_V;
                        remainder   <= '0;
                        div_by_zero <= 1'b0;
                    end else begin
                        q_reg  <= dvd_neg_c ? s0[XLEN-1:0] : q_reg;
                        d_reg  <= dvs_neg_c ? s1[XLEN-1:0] : d_reg;
                        p_reg  <= '0;
                        cnt    <= CNT_W'(XLEN - 1);
                        sign_q <= dvd_neg_c ^ dvs_neg_c;
                        sign_r <= dvd_neg_c;
                    end
                end
                ITER: begin
                    p_reg <= s0;
                    q_reg <= {q_reg[XLEN-2:0], ~s0[XLEN]};
                    cnt   <= cnt - CNT_W'(1);
                end
                FIX: begin
                    p_reg       <= s0;
                    quotient    <= sign_q ? s2[XLEN-1:0] : q_reg;
                    remainder   <= sign_r ? s1[XLEN-1:0] : s0[XLEN-1:0];
                    div_by_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_64.sv
// Bench for seq_div_64: arithmetic reference model plus directed vectors with literal results.
module tb_seq_div_64;

    typedef struct packed {
        logic [63:0] q;
        logic [63:0] r;
        logic        dbz;
    } res_t;

    localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        is_signed;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_by_zero;

    int   total = 0;
    int   bad   = 0;
    res_t exp_q[$];

    seq_div_64 #(.XLEN(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .is_signed(is_signed), .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division with the divider's special-case rules.
    function automatic res_t model(input logic s, input logic [63:0] a, input logic [63:0] b);
        res_t   e;
        longint sa;
        longint sb;
        e.dbz = 1'b0;
        if (b == 64'd0) begin
            e.q = ONES; e.r = a; e.dbz = 1'b1;
        end else if (s && a == MIN && b == ONES) begin
            e.q = MIN; e.r = 64'd0;
        end else if (s) begin
            sa = a; sb = b;
            e.q = 64'(sa / sb);
            e.r = 64'(sa % sb);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%h want 0x%h", nm, act, want);
        end
    endtask

    // Every cycle a result is presented it must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_result: got q=0x%h with no request outstanding", quotient);
            end else begin
                chk("model_q", quotient, exp_q[0].q);
                chk("model_r", remainder, exp_q[0].r);
                chk("model_dbz", 64'(div_by_zero), 64'(exp_q[0].dbz));
                chk("ready_while_valid", 64'(in_ready), 64'd0);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Present a request and hold it until accepted; returns just after the accept edge.
    task automatic issue(input logic s, input logic [63:0] a, input logic [63:0] b);
        int n;
        n = 0;
        is_signed = s; dividend = a; divisor = b; in_valid = 1'b1;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, want 1", in_ready, n);
        end
        exp_q.push_back(model(s, a, b));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Wait for out_valid, check latency (edges counted from the accept edge) and literal result.
    task automatic wait_result(input int lat_want, input logic [63:0] q_want,
                               input logic [63:0] r_want, input logic dbz_want);
        int lat;
        lat = 1;
        while (!out_valid && lat < 300) begin
            @(posedge clk); #1; lat++;
        end
        chk("latency", 64'(lat), 64'(lat_want));
        chk("lit_q", quotient, q_want);
        chk("lit_r", remainder, r_want);
        chk("lit_dbz", 64'(div_by_zero), 64'(dbz_want));
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_valid", 64'(out_valid), 64'd0);
        chk("release_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input logic s, input logic [63:0] a, input logic [63:0] b, input int lat,
                          input logic [63:0] q_want, input logic [63:0] r_want, input logic dbz_want);
        issue(s, a, b);
        wait_result(lat, q_want, r_want, dbz_want);
        consume();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   seen;
        res_t pin;
        rst = 1'b1; in_valid = 1'b0; is_signed = 1'b0;
        dividend = '0; divisor = '0; out_ready = 1'b1;

        // Pin the reference model against hand-computed values.
        pin = model(1'b0, 64'd100, 64'd7);
        chk("pin_u100_7_q", pin.q, 64'd14);
        pin = model(1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        chk("pin_sm7_2_r", pin.r, ONES);
        pin = model(1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("pin_s7_m2_q", pin.q, 64'hFFFF_FFFF_FFFF_FFFD);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_quotient", quotient, 64'd0);
        chk("rst_remainder", remainder, 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(1'b0, 64'd100, 64'd7, 67, 64'd14, 64'd2, 1'b0);
        run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 67, 64'hFFFF_FFFF_FFFF_FFFD, ONES, 1'b0);
        run_op(1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 67, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 1'b0);
        run_op(1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 67, 64'd14,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        run_op(1'b0, 64'h1234, 64'd0, 2, ONES, 64'h1234, 1'b1);
        run_op(1'b1, 64'h1234, 64'd0, 2, ONES, 64'h1234, 1'b1);
        run_op(1'b1, MIN, ONES, 2, MIN, 64'd0, 1'b0);
        run_op(1'b0, MIN, ONES, 67, 64'd0, MIN, 1'b0);
        run_op(1'b1, MIN, 64'd1, 67, MIN, 64'd0, 1'b0);
        run_op(1'b0, ONES, 64'd1, 67, ONES, 64'd0, 1'b0);
        run_op(1'b0, ONES, ONES, 67, 64'd1, 64'd0, 1'b0);
        run_op(1'b0, MIN, 64'd3, 67, 64'h2AAA_AAAA_AAAA_AAAA, 64'd2, 1'b0);
        run_op(1'b0, 64'd5, 64'd9, 67, 64'd0, 64'd5, 1'b0);
        run_op(1'b1, ONES, MIN, 67, 64'd0, ONES, 1'b0);

        // Backpressure: result held while a second request waits at the input.
        out_ready = 1'b0;
        issue(1'b0, 64'd1000, 64'd33);
        is_signed = 1'b1; dividend = 64'hFFFF_FFFF_FFFF_FF9C; divisor = 64'd7; in_valid = 1'b1;
        wait_result(67, 64'd30, 64'd10, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_ready", 64'(in_ready), 64'd0);
            chk("bp_q", quotient, 64'd30);
            chk("bp_r", remainder, 64'd10);
        end
        consume();
        out_ready = 1'b1;
        issue(1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7);
        wait_result(67, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        consume();

        // Reset in the middle of the iteration phase discards the operation.
        issue(1'b0, 64'd100, 64'd7);
        repeat (28) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_quotient", quotient, 64'd0);
        chk("midrst_remainder", remainder, 64'd0);
        chk("midrst_dbz", 64'(div_by_zero), 64'd0);
        seen = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("midrst_no_valid", 64'(seen), 64'd0);
        run_op(1'b0, 64'd100, 64'd7, 67, 64'd14, 64'd2, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
